// File: rtl/tnbuf_bus_arb.sv
// rtl/tnbuf_bus_arb.sv - round-robin tri-state bus arbiter with break-before-make turnaround
// Optional bus keeper on Z when TNBUF_KEEPER_EN is defined.
module tnbuf_bus_arb #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] DIN,
  output logic [NCH-1:0]       GNT,
  output logic [NCH-1:0]       ENB,
  output logic [WIDTH-1:0]     Z,
  output logic                 BUSY,
  output logic                 TURN_ACT
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;

  localparam logic [3:0]     TURN_LD  = 4'(TURN - 1);
  localparam logic [7:0]     HOLD_MAX = 8'(MAXHOLD);
  localparam logic [7:0]     HOLD_PRE = 8'(MAXHOLD - 1);
  localparam logic [NCH-1:0] ONE      = NCH'(1);

  logic [1:0]       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    nxt;
  logic [IW-1:0]    ptr;
  logic [3:0]       turn_cnt;
  logic [7:0]       hold_cnt;
  logic [IW-1:0]    owner_inc;
  logic             others;
  logic [WIDTH-1:0] din_sel;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (int'(i) == NCH - 1) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after start, wrapping modulo NCH.
  function automatic logic [IW-1:0] pick(input logic [NCH-1:0] r, input logic [IW-1:0] start);
    logic [IW-1:0] idx;
    logic [IW-1:0] res;
    logic          found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (r[idx] && !found) begin
        res   = idx;
        found = 1'b1;
      end
      idx = inc_idx(idx);
    end
    return res;
  endfunction

  assign owner_inc = inc_idx(owner);
  // GNT is one-hot on the owner while in OWN, so this masks the owner out.
  assign others    = |(REQ & ~GNT);
  assign din_sel   = DIN[int'(owner)*WIDTH +: WIDTH];

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state    <= S_IDLE;
      owner    <= '0;
      nxt      <= '0;
      ptr      <= '0;
      turn_cnt <= '0;
      hold_cnt <= '0;
      GNT      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            nxt      <= pick(REQ, ptr);
            turn_cnt <= TURN_LD;
            state    <= S_TURN;
          end
        end
        S_TURN: begin
          if (turn_cnt == 4'd0) begin
            state    <= S_OWN;
            owner    <= nxt;
            GNT      <= ONE << nxt;
            hold_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        S_OWN: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
          if (!REQ[owner] || (hold_cnt == HOLD_PRE && others)) begin
            ptr <= owner_inc;
            GNT <= '0;
            if (others) begin
              nxt      <= pick(REQ, owner_inc);
              turn_cnt <= TURN_LD;
              state    <= S_TURN;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ENB      = GNT;
  assign BUSY     = (state != S_IDLE);
  assign TURN_ACT = (state == S_TURN);

`ifdef TNBUF_KEEPER_EN
  logic [WIDTH-1:0] keep;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)     keep <= '0;
    else if (|GNT) keep <= din_sel;
  end

  assign Z = (|GNT) ? din_sel : keep;
`else
  assign Z = (|GNT) ? din_sel : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_tnbuf_bus_arb.sv
// tb/tb_tnbuf_bus_arb.sv - scoreboard bench for tnbuf_bus_arb (TURN=2, MAXHOLD=4)
module tb_tnbuf_bus_arb;

  localparam int WIDTH   = 8;
  localparam int NCH     = 4;
  localparam int TURN    = 2;
  localparam int MAXHOLD = 4;

  logic                 CLK  = 1'b0;
  logic                 RSTB = 1'b0;
  logic [NCH-1:0]       REQ  = '0;
  logic [NCH*WIDTH-1:0] DIN;
  logic [NCH-1:0]       GNT;
  logic [NCH-1:0]       ENB;
  wire  [WIDTH-1:0]     Z;
  logic                 BUSY;
  logic                 TURN_ACT;

  logic [WIDTH-1:0] din_a [NCH];
  logic [WIDTH-1:0] keep_m = '0;

  typedef struct packed {
    logic [NCH-1:0]   gnt;
    logic             busy;
    logic             ta;
    logic [WIDTH-1:0] z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  tnbuf_bus_arb #(.WIDTH(WIDTH), .NCH(NCH), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (
    .CLK(CLK), .RSTB(RSTB), .REQ(REQ), .DIN(DIN), .GNT(GNT), .ENB(ENB),
    .Z(Z), .BUSY(BUSY), .TURN_ACT(TURN_ACT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    DIN = '0;
    for (int i = 0; i < NCH; i++) DIN[i*WIDTH +: WIDTH] = din_a[i];
  end

  function automatic int oh2i(input logic [NCH-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < NCH; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Apply REQ, let the edge sample it, then queue the outputs expected after that edge.
  task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] g,
                      input logic b, input logic ta, input bit rst);
    exp_t e;
    if (!rst) RSTB = 1'b1;
    REQ = r;
    @(posedge CLK);
    #1;
    if (rst) begin
      RSTB   = 1'b0;
      keep_m = '0;
    end
    e.gnt  = g;
    e.busy = b;
    e.ta   = ta;
    if (g != '0) begin
      e.z    = din_a[oh2i(g)];
      keep_m = e.z;
    end else begin
`ifdef TNBUF_KEEPER_EN
      e.z = keep_m;
`else
      e.z = {WIDTH{1'bz}};
`endif
    end
    sb.push_back(e);
  endtask

  task automatic t_idle(input int n, input logic [NCH-1:0] r);
    repeat (n) step(r, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic t_turn(input int n, input logic [NCH-1:0] r);
    repeat (n) step(r, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic t_own(input int n, input logic [NCH-1:0] r, input logic [NCH-1:0] g);
    repeat (n) step(r, g, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt", 32'(GNT), 32'(e.gnt));
      chk("enb", 32'(ENB), 32'(e.gnt));
      chk("busy", 32'(BUSY), 32'(e.busy));
      chk("turn_act", 32'(TURN_ACT), 32'(e.ta));
      chk("z", {24'h0, Z}, {24'h0, e.z});
    end
  end

  initial begin
    din_a[0] = 8'h3C;
    din_a[1] = 8'h5A;
    din_a[2] = 8'h77;
    din_a[3] = 8'hC3;

    // reset held, then released into IDLE
    step('0, '0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);
    t_idle(2, 4'b0000);

    // sole requester keeps the bus well past MAXHOLD
    t_turn(2, 4'b0100);
    t_own(40, 4'b0100, 4'b0100);
    t_idle(2, 4'b0000);

    // asynchronous reset mid-OWN while channel 2 drives A5
    din_a[2] = 8'hA5;
    t_turn(2, 4'b0100);
    t_own(3, 4'b0100, 4'b0100);
    step(4'b0100, '0, 1'b0, 1'b0, 1'b1);
    step(4'b0100, '0, 1'b0, 1'b0, 1'b1);
    t_idle(1, 4'b0000);

    // all requesting: 0,1,2,3,0 with 4 OWN and 2 TURN cycles each
    t_turn(2, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      t_own(4, 4'b1111, NCH'(1) << (i % NCH));
      if (i < 4) t_turn(2, 4'b1111);
    end

    // owner 0 releases to 1; owner 1 releases while 3 rises: no IDLE in between
    t_turn(2, 4'b0010);
    t_own(2, 4'b0010, 4'b0010);
    t_turn(2, 4'b1000);
    t_own(2, 4'b1000, 4'b1000);
    t_idle(1, 4'b0000);

    // one-cycle pulse still wins one OWN cycle; pointer then sits at 1
    din_a[0] = 8'h96;
    t_turn(1, 4'b0001);
    t_turn(1, 4'b0000);
    t_own(1, 4'b0000, 4'b0001);
    t_idle(1, 4'b0000);
    t_turn(2, 4'b0011);
    t_own(1, 4'b0011, 4'b0010);
    t_idle(2, 4'b0000);

    repeat (3) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
